// File: rtl/alu_flag_ctrl_if.sv
// Bus between the ALU status consumer (flag controller) and its driver
// (sequencer). The master drives status/stack/condition requests, the slave
// returns the flag register, carry feedback, condition result and stack state.
interface alu_flag_ctrl_if #(
  parameter int FLAG_W = 6
);
  logic [FLAG_W-1:0] status_in;
  logic              upd_en;
  logic [FLAG_W-1:0] upd_mask;
  logic              sw_we;
  logic [FLAG_W-1:0] sw_data;
  logic              push;
  logic              pop;
  logic              cond_valid;
  logic [3:0]        cond_sel;
  logic              err_clr;
  logic [FLAG_W-1:0] flags_q;
  logic              cin_out;
  logic              cond_true;
  logic              cond_out_valid;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  modport master (
    output status_in, upd_en, upd_mask, sw_we, sw_data, push, pop,
           cond_valid, cond_sel, err_clr,
    input  flags_q, cin_out, cond_true, cond_out_valid, stk_full, stk_empty,
           stk_err
  );

  modport slave (
    input  status_in, upd_en, upd_mask, sw_we, sw_data, push, pop,
           cond_valid, cond_sel, err_clr,
    output flags_q, cin_out, cond_true, cond_out_valid, stk_full, stk_empty,
           stk_err
  );
endinterface

// File: rtl/alu_flag_ctrl.sv
// Flag controller: masked latching of the ALU status vector {C,Z,N,V,P,Af},
// carry feedback for chained ADC/SBB, a LIFO flag stack for interrupt
// save/restore and a 16-way branch condition evaluator with one-cycle latency.
module alu_flag_ctrl #(
  parameter int STACK_DEPTH = 4,
  parameter int FLAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_flag_ctrl_if.slave   bus
);

  localparam int ADDR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Flag bit positions
  localparam int C_BIT = 5;
  localparam int Z_BIT = 4;
  localparam int N_BIT = 3;
  localparam int V_BIT = 2;
  localparam int P_BIT = 1;

  logic [FLAG_W-1:0] flag_reg_q, flag_reg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              stk_err_q, stk_err_d;
  logic              cond_true_q, cond_true_d;
  logic              cond_vld_q, cond_vld_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];

  logic              full_s, empty_s;
  logic              push_ok_s, pop_ok_s, err_evt_s;
  logic [ADDR_W-1:0] wr_idx_s, top_idx_s;

  // Branch condition decode; C is the borrow on subtract, so HI/LS are the
  // unsigned compares with that polarity.
  function automatic logic cond_eval(
    input logic       c,
    input logic       z,
    input logic       n,
    input logic       v,
    input logic       p,
    input logic [3:0] sel
  );
    logic r;
    case (sel)
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = c;
      4'd3:    r = ~c;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = ~c & ~z;
      4'd9:    r = c | z;
      4'd10:   r = n ~^ v;
      4'd11:   r = n ^ v;
      4'd12:   r = ~z & (n ~^ v);
      4'd13:   r = z | (n ^ v);
      4'd14:   r = p;
      4'd15:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign full_s    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign wr_idx_s  = count_q[ADDR_W-1:0];
  assign top_idx_s = count_q[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};

  // Stack legality: simultaneous push/pop, overflow and underflow are errors
  always_comb begin
    push_ok_s = bus.push & ~bus.pop & ~full_s;
    pop_ok_s  = bus.pop & ~bus.push & ~empty_s;
    err_evt_s = (bus.push & bus.pop) |
                (bus.push & ~bus.pop & full_s) |
                (bus.pop & ~bus.push & empty_s);
  end

  // Next-state for flags, stack count, sticky error and condition result
  always_comb begin
    flag_reg_d  = flag_reg_q;
    count_d     = count_q;
    stk_err_d   = stk_err_q;
    cond_true_d = cond_true_q;
    cond_vld_d  = bus.cond_valid;

    if (bus.sw_we) begin
      flag_reg_d = bus.sw_data;
    end else if (pop_ok_s) begin
      flag_reg_d = stack_q[top_idx_s];
    end else if (bus.upd_en) begin
      flag_reg_d = (flag_reg_q & ~bus.upd_mask) | (bus.status_in & bus.upd_mask);
    end else begin
      flag_reg_d = flag_reg_q;
    end

    if (push_ok_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    // A new error event beats a coincident clear
    if (err_evt_s) begin
      stk_err_d = 1'b1;
    end else if (bus.err_clr) begin
      stk_err_d = 1'b0;
    end else begin
      stk_err_d = stk_err_q;
    end

    // Evaluated on the pre-edge flags; holds its last value otherwise
    if (bus.cond_valid) begin
      cond_true_d = cond_eval(flag_reg_q[C_BIT], flag_reg_q[Z_BIT],
                              flag_reg_q[N_BIT], flag_reg_q[V_BIT],
                              flag_reg_q[P_BIT], bus.cond_sel);
    end else begin
      cond_true_d = cond_true_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg_q  <= {FLAG_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      stk_err_q   <= 1'b0;
      cond_true_q <= 1'b0;
      cond_vld_q  <= 1'b0;
    end else begin
      flag_reg_q  <= flag_reg_d;
      count_q     <= count_d;
      stk_err_q   <= stk_err_d;
      cond_true_q <= cond_true_d;
      cond_vld_q  <= cond_vld_d;
    end
  end

  // Stack storage; contents are don't-care after reset so no reset needed
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      stack_q[wr_idx_s] <= flag_reg_q;
    end
  end

  assign bus.flags_q        = flag_reg_q;
  assign bus.cin_out        = flag_reg_q[C_BIT];
  assign bus.cond_true      = cond_true_q;
  assign bus.cond_out_valid = cond_vld_q;
  assign bus.stk_full       = full_s;
  assign bus.stk_empty      = empty_s;
  assign bus.stk_err        = stk_err_q;

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Directed bench for alu_flag_ctrl: flag update/masking, carry feedback,
// stack push/pop/errors, condition evaluation and mid-stream reset.
module tb_alu_flag_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_flag_ctrl_if #(.FLAG_W(6)) bus ();

  alu_flag_ctrl #(.STACK_DEPTH(4), .FLAG_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.status_in  = 6'h00;
    bus.upd_en     = 1'b0;
    bus.upd_mask   = 6'h00;
    bus.sw_we      = 1'b0;
    bus.sw_data    = 6'h00;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.cond_valid = 1'b0;
    bus.cond_sel   = 4'd0;
    bus.err_clr    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sw_flags(input logic [5:0] v);
    idle();
    bus.sw_we   = 1'b1;
    bus.sw_data = v;
    tick();
    idle();
  endtask

  task automatic cond_step(input logic [3:0] sel, input logic exp_v, input string tag);
    bus.cond_valid = 1'b1;
    bus.cond_sel   = sel;
    tick();
    chk({tag, "_vld"}, {7'd0, bus.cond_out_valid}, 8'd1);
    chk(tag, {7'd0, bus.cond_true}, {7'd0, exp_v});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_flags", {2'b00, bus.flags_q}, 8'h00);
    chk("rst_cin",   {7'd0, bus.cin_out}, 8'd0);
    chk("rst_cov",   {7'd0, bus.cond_out_valid}, 8'd0);
    chk("rst_ct",    {7'd0, bus.cond_true}, 8'd0);
    chk("rst_empty", {7'd0, bus.stk_empty}, 8'd1);
    chk("rst_full",  {7'd0, bus.stk_full}, 8'd0);
    chk("rst_err",   {7'd0, bus.stk_err}, 8'd0);

    // Full-mask update, then EQ condition
    bus.upd_en = 1'b1; bus.upd_mask = 6'h3F; bus.status_in = 6'b010010;
    tick(); idle();
    chk("upd_flags", {2'b00, bus.flags_q}, 8'h12);
    chk("upd_cin",   {7'd0, bus.cin_out}, 8'd0);
    cond_step(4'd0, 1'b1, "eq_after_upd");
    idle(); tick();
    chk("cov_drop", {7'd0, bus.cond_out_valid}, 8'd0);
    chk("ct_hold",  {7'd0, bus.cond_true}, 8'd1);

    // Carry-only mask
    sw_flags(6'h00);
    chk("sw_zero", {2'b00, bus.flags_q}, 8'h00);
    bus.upd_en = 1'b1; bus.upd_mask = 6'b100000; bus.status_in = 6'h3F;
    tick(); idle();
    chk("mask_c_flags", {2'b00, bus.flags_q}, 8'h20);
    chk("mask_c_cin",   {7'd0, bus.cin_out}, 8'd1);

    // Partial mask keeps unmasked bits
    bus.upd_en = 1'b1; bus.upd_mask = 6'b001010; bus.status_in = 6'b000000;
    tick(); idle();
    chk("mask_part", {2'b00, bus.flags_q}, 8'h20);
    bus.upd_en = 1'b1; bus.upd_mask = 6'b001010; bus.status_in = 6'h3F;
    tick(); idle();
    chk("mask_part2", {2'b00, bus.flags_q}, 8'h2A);

    // Fill the stack
    sw_flags(6'h01); bus.push = 1'b1; tick(); idle();
    sw_flags(6'h02); bus.push = 1'b1; tick(); idle();
    sw_flags(6'h04); bus.push = 1'b1; tick(); idle();
    chk("fill3_full", {7'd0, bus.stk_full}, 8'd0);
    sw_flags(6'h08); bus.push = 1'b1; tick(); idle();
    chk("full",       {7'd0, bus.stk_full}, 8'd1);
    chk("full_empty", {7'd0, bus.stk_empty}, 8'd0);
    chk("full_err0",  {7'd0, bus.stk_err}, 8'd0);

    // Overflow
    bus.push = 1'b1; tick(); idle();
    chk("ovf_err",  {7'd0, bus.stk_err}, 8'd1);
    chk("ovf_full", {7'd0, bus.stk_full}, 8'd1);
    bus.err_clr = 1'b1; tick(); idle();
    chk("errclr", {7'd0, bus.stk_err}, 8'd0);

    // Drain in LIFO order
    bus.pop = 1'b1; tick(); idle();
    chk("pop1", {2'b00, bus.flags_q}, 8'h08);
    chk("pop1_full", {7'd0, bus.stk_full}, 8'd0);
    bus.pop = 1'b1; tick(); idle();
    chk("pop2", {2'b00, bus.flags_q}, 8'h04);
    bus.pop = 1'b1; tick(); idle();
    chk("pop3", {2'b00, bus.flags_q}, 8'h02);
    bus.pop = 1'b1; tick(); idle();
    chk("pop4", {2'b00, bus.flags_q}, 8'h01);
    chk("pop4_empty", {7'd0, bus.stk_empty}, 8'd1);
    chk("pop4_err",   {7'd0, bus.stk_err}, 8'd0);

    // Underflow keeps flags
    bus.pop = 1'b1; tick(); idle();
    chk("unf_flags", {2'b00, bus.flags_q}, 8'h01);
    chk("unf_err",   {7'd0, bus.stk_err}, 8'd1);
    bus.err_clr = 1'b1; tick(); idle();

    // Push stores the pre-edge value while update proceeds
    bus.push = 1'b1; bus.upd_en = 1'b1; bus.status_in = 6'h3F; bus.upd_mask = 6'h3F;
    tick(); idle();
    chk("push_upd_flags", {2'b00, bus.flags_q}, 8'h3F);
    chk("push_upd_empty", {7'd0, bus.stk_empty}, 8'd0);
    bus.pop = 1'b1; tick(); idle();
    chk("restore", {2'b00, bus.flags_q}, 8'h01);

    // Pop beats upd_en
    bus.push = 1'b1; tick(); idle();
    sw_flags(6'h2A);
    bus.pop = 1'b1; bus.upd_en = 1'b1; bus.status_in = 6'h3F; bus.upd_mask = 6'h3F;
    tick(); idle();
    chk("pop_wins", {2'b00, bus.flags_q}, 8'h01);
    chk("pop_wins_empty", {7'd0, bus.stk_empty}, 8'd1);

    // sw_we beats pop, but the pop is still consumed
    bus.push = 1'b1; tick(); idle();
    bus.pop = 1'b1; bus.sw_we = 1'b1; bus.sw_data = 6'h15;
    tick(); idle();
    chk("sw_wins", {2'b00, bus.flags_q}, 8'h15);
    chk("sw_wins_empty", {7'd0, bus.stk_empty}, 8'd1);
    chk("sw_wins_err",   {7'd0, bus.stk_err}, 8'd0);

    // Condition sweep, C=1 N=1 V=0 Z=0 -> 6'b101000, back-to-back requests
    sw_flags(6'b101000);
    cond_step(4'd10, 1'b0, "ge");
    cond_step(4'd11, 1'b1, "lt");
    cond_step(4'd12, 1'b0, "gt");
    cond_step(4'd13, 1'b1, "le");
    cond_step(4'd8,  1'b0, "hi");
    cond_step(4'd9,  1'b1, "ls");
    cond_step(4'd15, 1'b1, "al");
    cond_step(4'd0,  1'b0, "eq");
    cond_step(4'd2,  1'b1, "cs");
    cond_step(4'd7,  1'b1, "vc");
    cond_step(4'd14, 1'b0, "pe");
    idle(); tick();
    chk("sweep_cov0", {7'd0, bus.cond_out_valid}, 8'd0);
    chk("sweep_hold", {7'd0, bus.cond_true}, 8'd0);

    // Condition uses pre-edge flags when a write coincides
    bus.sw_we = 1'b1; bus.sw_data = 6'b010000;
    cond_step(4'd0, 1'b0, "eq_preedge");
    idle();
    chk("preedge_flags", {2'b00, bus.flags_q}, 8'h10);
    cond_step(4'd0, 1'b1, "eq_post");
    idle();

    // Reset mid-stream: count=2, stk_err=1, pending condition
    bus.push = 1'b1; tick();
    tick(); idle();
    bus.push = 1'b1; bus.pop = 1'b1; tick(); idle();
    chk("conflict_err",   {7'd0, bus.stk_err}, 8'd1);
    chk("conflict_flags", {2'b00, bus.flags_q}, 8'h10);
    bus.pop = 1'b1; tick(); idle();
    chk("cnt2_pop", {7'd0, bus.stk_empty}, 8'd0);
    bus.push = 1'b1; tick(); idle();
    bus.cond_valid = 1'b1; bus.cond_sel = 4'd15; rst = 1'b1;
    tick(); idle(); rst = 1'b0;
    chk("mrst_flags", {2'b00, bus.flags_q}, 8'h00);
    chk("mrst_cov",   {7'd0, bus.cond_out_valid}, 8'd0);
    chk("mrst_ct",    {7'd0, bus.cond_true}, 8'd0);
    chk("mrst_empty", {7'd0, bus.stk_empty}, 8'd1);
    chk("mrst_full",  {7'd0, bus.stk_full}, 8'd0);
    chk("mrst_err",   {7'd0, bus.stk_err}, 8'd0);
    chk("mrst_cin",   {7'd0, bus.cin_out}, 8'd0);

    // Error wins over a coincident clear
    bus.pop = 1'b1; tick(); idle();
    chk("unf2_err", {7'd0, bus.stk_err}, 8'd1);
    bus.pop = 1'b1; bus.err_clr = 1'b1; tick(); idle();
    chk("err_beats_clr", {7'd0, bus.stk_err}, 8'd1);
    bus.err_clr = 1'b1; tick(); idle();
    chk("final_clr", {7'd0, bus.stk_err}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
